// File: rtl/branch_resolution_controller_if.sv
// ID-stage branch resolution bus: decoded Bicc fields, flags and hazard inputs
// in one direction, stall/resolve/annul controls in the other.
interface branch_resolution_controller_if;
   logic       ID_branch_instr;
   logic [3:0] ID_cond;
   logic       ID_annul;
   logic [3:0] flags_in;
   logic       EX_modcc;
   logic       pipe_hold;
   logic       stall_out;
   logic       resolve_valid;
   logic       branch_taken;
   logic       annul_slot;
   logic       dcti_error;
   logic       busy;

   modport master (
      output ID_branch_instr, ID_cond, ID_annul, flags_in, EX_modcc, pipe_hold,
      input  stall_out, resolve_valid, branch_taken, annul_slot, dcti_error, busy
   );

   modport slave (
      input  ID_branch_instr, ID_cond, ID_annul, flags_in, EX_modcc, pipe_hold,
      output stall_out, resolve_valid, branch_taken, annul_slot, dcti_error, busy
   );
endinterface

// File: rtl/branch_resolution_controller.sv
// Resolves Bicc branches in ID: waits out icc hazards, evaluates the condition,
// selects the PC, annuls the delay slot and flags illegal DCTI couples.
module branch_resolution_controller #(
   parameter int CC_LATENCY = 1
) (
   input logic                         clk,
   input logic                         reset,
   branch_resolution_controller_if.slave bus
);
   localparam int CNT_W = $clog2(CC_LATENCY) + 1;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      CC_WAIT    = 2'd1,
      DELAY_SLOT = 2'd2
   } state_t;

   state_t           state_r;
   state_t           next_state_s;
   logic [CNT_W-1:0] count_r;
   logic             slot_annulled_r;
   logic             hazard_s;
   logic             needs_cc_s;
   logic             taken_s;
   logic             stall_s;
   logic             resolve_s;
   logic             annul_s;
   logic             dcti_s;

   // Codes 1xxx are the complements of 0xxx, which also turns "never" into "always".
   function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] icc);
      logic base;
      case (cond[2:0])
         3'b000:  base = 1'b0;
         3'b001:  base = icc[2];
         3'b010:  base = icc[2] | (icc[3] ^ icc[1]);
         3'b011:  base = icc[3] ^ icc[1];
         3'b100:  base = icc[0] | icc[2];
         3'b101:  base = icc[0];
         3'b110:  base = icc[3];
         3'b111:  base = icc[1];
         default: base = 1'b0;
      endcase
      return cond[3] ? ~base : base;
   endfunction

   assign hazard_s   = bus.EX_modcc | (count_r != {CNT_W{1'b0}});
   assign needs_cc_s = (bus.ID_cond[2:0] != 3'b000);
   assign taken_s    = cond_eval(bus.ID_cond, bus.flags_in);

   // Cycles remaining until the icc written by EX becomes visible on flags_in.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_r <= {CNT_W{1'b0}};
      end else if (!bus.pipe_hold && bus.EX_modcc) begin
         count_r <= CNT_W'(CC_LATENCY - 1);
      end else if (!bus.pipe_hold && (count_r != {CNT_W{1'b0}})) begin
         count_r <= count_r - CNT_W'(1);
      end else begin
         count_r <= count_r;
      end
   end

   // State register plus the annulled-slot flag captured at resolve.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r         <= IDLE;
         slot_annulled_r <= 1'b0;
      end else begin
         state_r         <= next_state_s;
         slot_annulled_r <= resolve_s ? annul_s : slot_annulled_r;
      end
   end

   // Next-state and Mealy outputs; resolution happens in the cycle it is decided.
   always_comb begin
      next_state_s = state_r;
      stall_s      = 1'b0;
      resolve_s    = 1'b0;
      dcti_s       = 1'b0;
      if (reset) begin
         next_state_s = IDLE;
      end else if (bus.pipe_hold) begin
         stall_s = (state_r == CC_WAIT) & hazard_s;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.ID_branch_instr && hazard_s && needs_cc_s) begin
                  stall_s      = 1'b1;
                  next_state_s = CC_WAIT;
               end else if (bus.ID_branch_instr) begin
                  resolve_s    = 1'b1;
                  next_state_s = DELAY_SLOT;
               end else begin
                  next_state_s = IDLE;
               end
            end
            CC_WAIT: begin
               stall_s = hazard_s;
               if (!hazard_s) begin
                  resolve_s    = 1'b1;
                  next_state_s = DELAY_SLOT;
               end else begin
                  next_state_s = CC_WAIT;
               end
            end
            DELAY_SLOT: begin
               dcti_s       = bus.ID_branch_instr & ~slot_annulled_r;
               next_state_s = IDLE;
            end
            default: begin
               next_state_s = IDLE;
            end
         endcase
      end
   end

   assign annul_s = resolve_s & bus.ID_annul & (~taken_s | (bus.ID_cond == 4'b1000));

   assign bus.stall_out     = stall_s;
   assign bus.resolve_valid = resolve_s;
   assign bus.branch_taken  = resolve_s & taken_s;
   assign bus.annul_slot    = annul_s;
   assign bus.dcti_error    = dcti_s;
   assign bus.busy          = (state_r != IDLE);
endmodule

// File: tb/tb_branch_resolution_controller.sv
// Directed bench for branch_resolution_controller with CC_LATENCY=2.
module tb_branch_resolution_controller;
   logic clk;
   logic reset;
   int   checks;
   int   failures;

   branch_resolution_controller_if bus ();

   branch_resolution_controller #(.CC_LATENCY(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic br, input logic [3:0] cond, input logic a,
                        input logic [3:0] flags, input logic modcc, input logic hold);
      bus.ID_branch_instr = br;
      bus.ID_cond         = cond;
      bus.ID_annul        = a;
      bus.flags_in        = flags;
      bus.EX_modcc        = modcc;
      bus.pipe_hold       = hold;
      #2;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
      tick();
      tick();
      reset = 1'b0;
      drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_stall", bus.stall_out, 1'b0);
      chk("rst_resolve", bus.resolve_valid, 1'b0);

      // be, Z set, no hazard
      drive(1'b1, 4'b0001, 1'b0, 4'b0100, 1'b0, 1'b0);
      chk("be_resolve", bus.resolve_valid, 1'b1);
      chk("be_taken", bus.branch_taken, 1'b1);
      chk("be_annul", bus.annul_slot, 1'b0);
      chk("be_stall", bus.stall_out, 1'b0);
      tick();
      drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
      chk("be_slot_busy", bus.busy, 1'b1);
      chk("be_slot_resolve", bus.resolve_valid, 1'b0);
      tick();
      chk("be_idle_busy", bus.busy, 1'b0);

      // bne behind a cc-setter, two cycles of stall
      drive(1'b1, 4'b1001, 1'b0, 4'b0000, 1'b1, 1'b0);
      chk("haz_t0_stall", bus.stall_out, 1'b1);
      chk("haz_t0_resolve", bus.resolve_valid, 1'b0);
      tick();
      drive(1'b1, 4'b1001, 1'b0, 4'b0000, 1'b0, 1'b0);
      chk("haz_t1_stall", bus.stall_out, 1'b1);
      chk("haz_t1_busy", bus.busy, 1'b1);
      chk("haz_t1_resolve", bus.resolve_valid, 1'b0);
      tick();
      chk("haz_t2_stall", bus.stall_out, 1'b0);
      chk("haz_t2_resolve", bus.resolve_valid, 1'b1);
      chk("haz_t2_taken", bus.branch_taken, 1'b1);
      tick();
      drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
      tick();

      // ba,a ignores a pending cc write and annuls
      drive(1'b1, 4'b1000, 1'b1, 4'b0000, 1'b1, 1'b0);
      chk("ba_stall", bus.stall_out, 1'b0);
      chk("ba_resolve", bus.resolve_valid, 1'b1);
      chk("ba_taken", bus.branch_taken, 1'b1);
      chk("ba_annul", bus.annul_slot, 1'b1);
      tick();
      // branch in an annulled slot is not an error
      drive(1'b1, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
      chk("ba_slot_dcti", bus.dcti_error, 1'b0);
      chk("ba_slot_resolve", bus.resolve_valid, 1'b0);
      tick();
      drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
      tick();

      // bn,a
      drive(1'b1, 4'b0000, 1'b1, 4'b1111, 1'b0, 1'b0);
      chk("bn_taken", bus.branch_taken, 1'b0);
      chk("bn_annul", bus.annul_slot, 1'b1);
      tick();
      drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
      tick();

      // bl,a taken (N=1, V=0), then a DCTI couple in the live slot
      drive(1'b1, 4'b0011, 1'b1, 4'b1000, 1'b0, 1'b0);
      chk("bl_t_taken", bus.branch_taken, 1'b1);
      chk("bl_t_annul", bus.annul_slot, 1'b0);
      tick();
      drive(1'b1, 4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0);
      chk("dcti_pulse", bus.dcti_error, 1'b1);
      chk("dcti_resolve", bus.resolve_valid, 1'b0);
      tick();
      drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
      chk("dcti_clear", bus.dcti_error, 1'b0);
      chk("dcti_idle", bus.busy, 1'b0);

      // bl,a not taken
      drive(1'b1, 4'b0011, 1'b1, 4'b0000, 1'b0, 1'b0);
      chk("bl_nt_taken", bus.branch_taken, 1'b0);
      chk("bl_nt_annul", bus.annul_slot, 1'b1);
      tick();
      drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
      tick();

      // reset while waiting on cc
      drive(1'b1, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0);
      chk("rcw_stall0", bus.stall_out, 1'b1);
      tick();
      drive(1'b1, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
      chk("rcw_busy", bus.busy, 1'b1);
      chk("rcw_stall1", bus.stall_out, 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      drive(1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
      chk("rcw_after_stall", bus.stall_out, 1'b0);
      chk("rcw_after_busy", bus.busy, 1'b0);
      chk("rcw_after_resolve", bus.resolve_valid, 1'b0);

      // pipe_hold on a resolvable branch
      drive(1'b1, 4'b0001, 1'b0, 4'b0100, 1'b0, 1'b1);
      chk("hold_resolve", bus.resolve_valid, 1'b0);
      chk("hold_taken", bus.branch_taken, 1'b0);
      chk("hold_stall", bus.stall_out, 1'b0);
      tick();
      chk("hold_state", bus.busy, 1'b0);
      drive(1'b1, 4'b0001, 1'b0, 4'b0100, 1'b0, 1'b0);
      chk("hold_rel_resolve", bus.resolve_valid, 1'b1);
      chk("hold_rel_taken", bus.branch_taken, 1'b1);
      tick();
      drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
      chk("hold_rel_slot", bus.busy, 1'b1);
      tick();

      // pipe_hold freezes the cc counter inside CC_WAIT
      drive(1'b1, 4'b0001, 1'b0, 4'b0100, 1'b1, 1'b0);
      tick();
      drive(1'b1, 4'b0001, 1'b0, 4'b0100, 1'b0, 1'b1);
      chk("hcw_stall", bus.stall_out, 1'b1);
      chk("hcw_resolve", bus.resolve_valid, 1'b0);
      tick();
      drive(1'b1, 4'b0001, 1'b0, 4'b0100, 1'b0, 1'b0);
      chk("hcw_frozen_stall", bus.stall_out, 1'b1);
      chk("hcw_frozen_resolve", bus.resolve_valid, 1'b0);
      tick();
      chk("hcw_done_resolve", bus.resolve_valid, 1'b1);
      chk("hcw_done_stall", bus.stall_out, 1'b0);
      chk("hcw_done_taken", bus.branch_taken, 1'b1);
      tick();
      drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
